// File: rtl/snake_fb_pkg.sv
// Shared constants, types and helpers for the snake frame buffer writer.
package snake_fb_pkg;

    localparam int GRID     = 75;
    localparam int FB_WORDS = GRID * GRID;
    localparam int FB_AW    = 13;
    localparam int CW       = 7;

    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(FB_WORDS - 1);
    localparam logic [CW-1:0]    GRID_C    = CW'(GRID);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_e;

    // One queued paint request
    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [11:0]   color;
        logic [3:0]    tag;
    } fb_req_t;

    localparam int REQ_W = $bits(fb_req_t);

    // x + 75*y as shifts and adds: 75 = 64 + 8 + 2 + 1; max 5624 fits 13 bits
    function automatic logic [FB_AW-1:0] cell_addr(input logic [CW-1:0] x,
                                                   input logic [CW-1:0] y);
        return {6'b0, x} + {y, 6'b0} + {3'b0, y, 3'b0} + {5'b0, y, 1'b0} + {6'b0, y};
    endfunction

    // Stored word: colour in [15:4], tag in [3:0]
    function automatic logic [15:0] pack_word(input logic [11:0] color,
                                              input logic [3:0]  tag);
        return {color, tag};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous show-ahead FIFO; rd_data is the head entry whenever !empty.
module sync_fifo #(
    parameter int W     = 30,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;

    assign rd_data = mem[rp];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wr_data;
    end

    // Pointers and occupancy; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/snake_fb_writer.sv
// Write-side engine for the 75x75 snake frame buffer: queued cell paints plus clear sweeps.
module snake_fb_writer
    import snake_fb_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter bit VBLANK_GATE = 1'b1
) (
    input  logic             pclk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_x,
    input  logic [6:0]       req_y,
    input  logic [11:0]      req_color,
    input  logic [3:0]       req_tag,
    input  logic             clr_start,
    input  logic [11:0]      clr_color,
    input  logic             vblank,
    output logic             we,
    output logic [FB_AW-1:0] waddr,
    output logic [15:0]      wdata,
    output logic             busy,
    output logic             clr_done,
    output logic             err_oob
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fb_state_e        state, state_d;
    logic [FB_AW-1:0] cnt, cnt_d;
    logic [11:0]      clr_color_q, clr_color_d;
    logic             we_d, clr_done_d;
    logic [FB_AW-1:0] waddr_d;
    logic [15:0]      wdata_d;

    fb_req_t          wr_req, rd_req;
    logic             push, pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             xfer, in_range;

    // Ready depends only on registered occupancy, so a full FIFO refuses even while popping
    assign req_ready = rstn && !fifo_full;
    assign xfer      = req_valid && req_ready;
    assign in_range  = (req_x < GRID_C) && (req_y < GRID_C);
    assign push      = xfer && in_range;
    assign wr_req    = '{x: req_x, y: req_y, color: req_color, tag: req_tag};

    // clr_done keeps busy up through the final clear write
    assign busy = (state == CLEAR) || (fifo_count != '0) || clr_done;

    sync_fifo #(.W(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (pclk),
        .rstn    (rstn),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_req),
        .rd_data (rd_req),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state and next-write selection: clear beats draining; draining waits on the gate
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        clr_color_d = clr_color_q;
        pop         = 1'b0;
        we_d        = 1'b0;
        waddr_d     = waddr;
        wdata_d     = wdata;
        clr_done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_d     = CLEAR;
                    cnt_d       = '0;
                    clr_color_d = clr_color;
                end else if (!fifo_empty && (!VBLANK_GATE || vblank)) begin
                    pop     = 1'b1;
                    we_d    = 1'b1;
                    waddr_d = cell_addr(rd_req.x, rd_req.y);
                    wdata_d = pack_word(rd_req.color, rd_req.tag);
                end
            end
            CLEAR: begin
                we_d    = 1'b1;
                waddr_d = cnt;
                wdata_d = pack_word(clr_color_q, 4'h0);
                if (cnt == LAST_ADDR) begin
                    clr_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt + FB_AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, sweep counter and registered RAM write port
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            clr_color_q <= '0;
            we          <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
            clr_done    <= 1'b0;
            err_oob     <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            clr_color_q <= clr_color_d;
            we          <= we_d;
            waddr       <= waddr_d;
            wdata       <= wdata_d;
            clr_done    <= clr_done_d;
            err_oob     <= xfer && !in_range;
        end
    end

endmodule

// File: tb/tb_snake_fb_writer.sv
// Directed self-checking bench for snake_fb_writer (FIFO_DEPTH=4, VBLANK_GATE=1).
module tb_snake_fb_writer;

    logic        pclk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_x, req_y;
    logic [11:0] req_color;
    logic [3:0]  req_tag;
    logic        clr_start;
    logic [11:0] clr_color;
    logic        vblank;
    logic        we;
    logic [12:0] waddr;
    logic [15:0] wdata;
    logic        busy, clr_done, err_oob;

    int tests = 0;
    int fails = 0;

    // Back-to-back vectors: hand-computed addresses x + 75*y
    int          bx   [5] = '{0, 74, 10, 1, 5};
    int          by   [5] = '{0, 74, 1, 10, 5};
    int          badr [4] = '{0, 5624, 85, 751};
    logic [15:0] bdat [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    snake_fb_writer #(.FIFO_DEPTH(4), .VBLANK_GATE(1'b1)) dut (
        .pclk(pclk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_color(req_color), .req_tag(req_tag),
        .clr_start(clr_start), .clr_color(clr_color), .vblank(vblank),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
        .clr_done(clr_done), .err_oob(err_oob)
    );

    always #5 pclk = ~pclk;

    // Advance one clock; outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive_req(input int x, input int y, input logic [11:0] c, input logic [3:0] t);
        req_valid = 1'b1;
        req_x     = 7'(x);
        req_y     = 7'(y);
        req_color = c;
        req_tag   = t;
    endtask

    // Wait up to n cycles for we=1; counts a failure if it never comes
    task automatic wait_we(input int n, input string name);
        int k;
        for (k = 0; k < n && !we; k++) tick();
        tests++;
        if (!we) begin
            fails++;
            $display("FAIL %s: we=%0b after %0d cycles, required 1", name, we, n);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(); tick();
        tests++;
        if ({we, waddr, wdata, busy, clr_done, err_oob, req_ready} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: we=%0b waddr=%0d wdata=%h busy=%0b done=%0b oob=%0b rdy=%0b, required all 0",
                     we, waddr, wdata, busy, clr_done, err_oob, req_ready);
        end
        rstn = 1'b1;
        tick();
        tests++;
        if (req_ready !== 1'b1 || we !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: rdy=%0b we=%0b, required rdy=1 we=0", req_ready, we);
        end
    endtask

    task automatic test_single();
        vblank = 1'b1;
        drive_req(3, 2, 12'hF00, 4'h1);
        tick();
        req_valid = 1'b0;
        tests++;
        if (we !== 1'b0) begin
            fails++; $display("FAIL single_early: we=%0b, required 0", we);
        end
        tick();
        tests++;
        if (we !== 1'b1 || waddr !== 13'd153 || wdata !== 16'hF001) begin
            fails++;
            $display("FAIL single_write: we=%0b waddr=%0d wdata=%h, required 1/153/f001", we, waddr, wdata);
        end
        tick();
        tests++;
        if (we !== 1'b0 || waddr !== 13'd153 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_after: we=%0b waddr=%0d busy=%0b, required 0/153/0", we, waddr, busy);
        end
    endtask

    task automatic test_clear();
        int bad = 0;
        int last_ok = 0;
        vblank    = 1'b0;
        clr_color = 12'h00F;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        clr_color = 12'h777;  // must not affect the latched fill colour
        wait_we(4, "clear_start");
        for (int i = 0; i < 5625; i++) begin
            if (we !== 1'b1 || waddr !== 13'(i) || wdata !== 16'h00F0 || clr_done !== (i == 5624)) begin
                if (bad == 0)
                    $display("FAIL clear_sweep: i=%0d we=%0b waddr=%0d wdata=%h done=%0b, required 1/%0d/00f0/%0b",
                             i, we, waddr, wdata, clr_done, i, i == 5624);
                bad++;
            end
            if (i == 5624 && busy === 1'b1) last_ok = 1;
            clr_start = (i == 10);  // restart attempt mid-sweep must be ignored
            if (i < 5624) tick();
        end
        clr_start = 1'b0;
        tests++;
        if (bad != 0) fails++;
        tests++;
        if (last_ok != 1) begin
            fails++; $display("FAIL clear_busy_last: busy=%0b, required 1", busy);
        end
        tick();
        tests++;
        if (we !== 1'b0 || busy !== 1'b0 || clr_done !== 1'b0) begin
            fails++;
            $display("FAIL clear_end: we=%0b busy=%0b done=%0b, required 0/0/0", we, busy, clr_done);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        vblank = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_req(bx[k], by[k], 12'(12'h111 * (k + 1)), 4'(k + 1));
            tests++;
            if (req_ready !== (k < 4)) begin
                fails++;
                $display("FAIL b2b_ready_%0d: rdy=%0b, required %0b", k, req_ready, k < 4);
            end
            tick();
        end
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (we !== 1'b0) bad++;
            tick();
        end
        tests++;
        if (bad != 0 || busy !== 1'b1) begin
            fails++; $display("FAIL b2b_gated: writes=%0d busy=%0b, required 0/1", bad, busy);
        end
        vblank = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (we !== 1'b1 || waddr !== 13'(badr[k]) || wdata !== bdat[k]) begin
                fails++;
                $display("FAIL b2b_write_%0d: we=%0b waddr=%0d wdata=%h, required 1/%0d/%h",
                         k, we, waddr, wdata, badr[k], bdat[k]);
            end
            tick();
        end
        tests++;
        if (we !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL b2b_end: we=%0b busy=%0b, required 0/0", we, busy);
        end
    endtask

    task automatic test_gate();
        vblank = 1'b0;
        drive_req(2, 0, 12'hA0A, 4'h3); tick();
        drive_req(0, 1, 12'hB0B, 4'h4); tick();
        req_valid = 1'b0;
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tests++;
        if (we !== 1'b1 || waddr !== 13'd2 || wdata !== 16'hA0A3) begin
            fails++; $display("FAIL gate_first: we=%0b waddr=%0d wdata=%h, required 1/2/a0a3", we, waddr, wdata);
        end
        tick();
        tests++;
        if (we !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL gate_closed: we=%0b busy=%0b, required 0/1", we, busy);
        end
        vblank = 1'b1;
        tick();
        tests++;
        if (we !== 1'b1 || waddr !== 13'd75 || wdata !== 16'hB0B4) begin
            fails++; $display("FAIL gate_second: we=%0b waddr=%0d wdata=%h, required 1/75/b0b4", we, waddr, wdata);
        end
        tick();
    endtask

    task automatic test_oob();
        vblank = 1'b1;
        drive_req(75, 0, 12'hFFF, 4'hF);
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL oob_ready: rdy=%0b, required 1", req_ready);
        end
        tick();
        drive_req(0, 75, 12'hFFF, 4'hF);
        tests++;
        if (err_oob !== 1'b1 || we !== 1'b0) begin
            fails++; $display("FAIL oob_x: oob=%0b we=%0b, required 1/0", err_oob, we);
        end
        tick();
        req_valid = 1'b0;
        tests++;
        if (err_oob !== 1'b1 || we !== 1'b0) begin
            fails++; $display("FAIL oob_y: oob=%0b we=%0b, required 1/0", err_oob, we);
        end
        tick();
        tests++;
        if (err_oob !== 1'b0 || we !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL oob_after: oob=%0b we=%0b busy=%0b, required 0/0/0", err_oob, we, busy);
        end
    endtask

    task automatic test_mid_clear();
        int bad = 0;
        int k;
        vblank    = 1'b1;
        clr_color = 12'hCCC;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (k = 0; k < 200 && !(we && waddr == 13'd100); k++) tick();
        drive_req(7, 3, 12'hABC, 4'h5);
        tests++;
        if (req_ready !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL midclr_accept: rdy=%0b busy=%0b, required 1/1", req_ready, busy);
        end
        tick();
        req_valid = 1'b0;
        for (k = 0; k < 6000 && !clr_done; k++) begin
            if (we && wdata !== 16'hCCC0) bad++;
            tick();
        end
        tests++;
        if (bad != 0 || clr_done !== 1'b1 || waddr !== 13'd5624) begin
            fails++;
            $display("FAIL midclr_sweep: stray=%0d done=%0b waddr=%0d, required 0/1/5624", bad, clr_done, waddr);
        end
        tick();
        tests++;
        if (we !== 1'b1 || waddr !== 13'd232 || wdata !== 16'hABC5) begin
            fails++; $display("FAIL midclr_queued: we=%0b waddr=%0d wdata=%h, required 1/232/abc5", we, waddr, wdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int bad = 0;
        int k;
        vblank    = 1'b1;
        clr_color = 12'h0F0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (k = 0; k < 2100 && !(we && waddr == 13'd2000); k++) tick();
        tests++;
        if (!(we && waddr == 13'd2000)) begin
            fails++; $display("FAIL rstclr_reach: we=%0b waddr=%0d, required 1/2000", we, waddr);
        end
        drive_req(1, 1, 12'h123, 4'h6);  // queued, must be flushed by reset
        tick();
        req_valid = 1'b0;
        rstn = 1'b0;
        tick();
        tests++;
        if (we !== 1'b0 || busy !== 1'b0 || clr_done !== 1'b0) begin
            fails++; $display("FAIL rstclr_reset: we=%0b busy=%0b done=%0b, required 0/0/0", we, busy, clr_done);
        end
        rstn = 1'b1;
        for (k = 0; k < 20; k++) begin
            tick();
            if (we !== 1'b0 || busy !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL rstclr_quiet: %0d cycles with we/busy, required 0", bad);
        end
    endtask

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0; req_color = '0; req_tag = '0;
        clr_start = 1'b0; clr_color = '0; vblank = 1'b0;
        test_reset();
        test_single();
        test_clear();
        test_back_to_back();
        test_gate();
        test_oob();
        test_mid_clear();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
